crack_job_scheduler: RTL and testbench

//  Sequences a bank of NUM_ENGINES brute-force password_cracker engines. Accepts one

---
 rtl/crack_pkg.sv | 44 ++++
 rtl/crack_prio_enc.sv | 24 ++
 rtl/crack_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_crack_job_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared types, constants and slice helper for the crack scheduler
// Purpose: symbol-set constants, scheduler state encoding and the static
//          search-space slicing function used to partition the first symbol.
// Ports:   none (package).
package crack_pkg;

  localparam int CHARSET    = 36;
  localparam int SYM_W      = 6;
  localparam int ASCII_ZERO = 48;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    REPORT
  } state_t;

  // One extra bit over SYM_W so a slice start past the last symbol is
  // representable and recognised as "engine unused" instead of wrapping.
  typedef struct packed {
    logic             en;
    logic [SYM_W:0]   from;
    logic [SYM_W:0]   to;
  } slice_t;

  // Slice for engine i of n over cs symbols: ceil-sized contiguous chunks,
  // the last one clipped to cs-1. Unused engines get from=to=0.
  function automatic slice_t slice_bounds(input int i, input int n, input int cs);
    int     sl;
    int     f;
    int     t;
    slice_t r;
    sl = (cs + n - 1) / n;
    f  = i * sl;
    t  = f + sl - 1;
    if (t > cs - 1) t = cs - 1;
    r.en   = (f <= cs - 1);
    r.from = r.en ? f[SYM_W:0] : '0;
    r.to   = r.en ? t[SYM_W:0] : '0;
    return r;
  endfunction

endpackage

// File: rtl/crack_prio_enc.sv
// rtl/crack_prio_enc.sv - lowest-index-first priority encoder
// Purpose: reports whether any request bit is set and the lowest set index.
// Ports:   i_req  N-bit request vector
//          o_any  1 when any bit of i_req is set
//          o_idx  index of the lowest set bit (0 when none)
module crack_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the last (lowest) hit wins.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) o_idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/crack_job_scheduler.sv
// rtl/crack_job_scheduler.sv - sequences a bank of brute-force cracker engines
// Purpose: accepts one job, hands each engine a slice of the first-symbol space,
//          runs the bank and reports the lowest-index hit, exhaustion or abort
//          together with the number of RUN cycles spent.
// Ports:   clk, rst             clock, async active-high reset
//          i_start, i_abort     job request (IDLE only) / cancel (LOAD..RUN)
//          i_target_pwd         4 ASCII chars captured on accepted start
//          o_eng_rst            per-engine load/reset, 1 = held
//          o_eng_pwd            captured target, shared by all engines
//          o_eng_from/o_eng_to  per-engine slice bounds, SYM_W each, engine i at [i*SYM_W +: SYM_W]
//          i_eng_found/i_eng_done per-engine sticky status
//          o_busy               job accepted and not yet reported
//          o_job_done           1-cycle completion pulse
//          o_job_found          hit flag, valid with o_job_done
//          o_job_engine         winning engine index, valid when o_job_found
//          o_job_cycles         RUN cycles of the last job, held until next start
module crack_job_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int CHARSET     = crack_pkg::CHARSET,
  parameter int SYM_W       = crack_pkg::SYM_W,
  parameter int CYC_W       = 32,
  localparam int IDX_W      = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [31:0]                  i_target_pwd,
  output logic [NUM_ENGINES-1:0]       o_eng_rst,
  output logic [31:0]                  o_eng_pwd,
  output logic [NUM_ENGINES*SYM_W-1:0] o_eng_from,
  output logic [NUM_ENGINES*SYM_W-1:0] o_eng_to,
  input  logic [NUM_ENGINES-1:0]       i_eng_found,
  input  logic [NUM_ENGINES-1:0]       i_eng_done,
  output logic                         o_busy,
  output logic                         o_job_done,
  output logic                         o_job_found,
  output logic [IDX_W-1:0]             o_job_engine,
  output logic [CYC_W-1:0]             o_job_cycles
);

  import crack_pkg::*;

  localparam int EW = NUM_ENGINES * SYM_W;

  logic [NUM_ENGINES-1:0] w_en;
  logic [EW-1:0]          w_from;
  logic [EW-1:0]          w_to;
  logic [NUM_ENGINES-1:0] w_found_en;
  logic                   w_any_found;
  logic [IDX_W-1:0]       w_found_idx;
  logic                   w_all_done;

  // Slices depend only on parameters, so they are elaborated as constants.
  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_slice
    localparam slice_t SB = slice_bounds(g, NUM_ENGINES, CHARSET);
    assign w_en[g]                    = SB.en;
    assign w_from[g*SYM_W +: SYM_W]   = SB.from[SYM_W-1:0];
    assign w_to[g*SYM_W +: SYM_W]     = SB.to[SYM_W-1:0];
  end

  // Unused engines never search: mask their hits and treat them as finished.
  assign w_found_en = i_eng_found & w_en;
  assign w_all_done = &(i_eng_done | ~w_en);

  crack_prio_enc #(
    .N     (NUM_ENGINES),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_req (w_found_en),
    .o_any (w_any_found),
    .o_idx (w_found_idx)
  );

  state_t r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      o_eng_rst    <= '1;
      o_eng_pwd    <= '0;
      o_eng_from   <= '0;
      o_eng_to     <= '0;
      o_busy       <= 1'b0;
      o_job_done   <= 1'b0;
      o_job_found  <= 1'b0;
      o_job_engine <= '0;
      o_job_cycles <= '0;
    end else begin
      o_job_done <= 1'b0;
      case (r_state)
        IDLE: begin
          o_eng_rst <= '1;
          if (i_start) begin
            r_state      <= LOAD;
            o_busy       <= 1'b1;
            o_eng_pwd    <= i_target_pwd;
            o_eng_from   <= w_from;
            o_eng_to     <= w_to;
            o_job_found  <= 1'b0;
            o_job_engine <= '0;
            o_job_cycles <= '0;
          end
        end
        // Engines stay in reset for this cycle to latch from/to/pwd.
        LOAD: begin
          if (i_abort) begin
            r_state    <= REPORT;
            o_job_done <= 1'b1;
          end else begin
            r_state   <= SETTLE;
            o_eng_rst <= ~w_en;
          end
        end
        // Engine status is still stale from before the release; not sampled.
        SETTLE: begin
          if (i_abort) begin
            r_state    <= REPORT;
            o_job_done <= 1'b1;
            o_eng_rst  <= '1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (o_job_cycles != '1) o_job_cycles <= o_job_cycles + CYC_W'(1);
          if (i_abort) begin
            r_state    <= REPORT;
            o_job_done <= 1'b1;
            o_eng_rst  <= '1;
          end else if (w_any_found) begin
            r_state      <= REPORT;
            o_job_done   <= 1'b1;
            o_job_found  <= 1'b1;
            o_job_engine <= w_found_idx;
            o_eng_rst    <= '1;
          end else if (w_all_done) begin
            r_state    <= REPORT;
            o_job_done <= 1'b1;
            o_eng_rst  <= '1;
          end
        end
        REPORT: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crack_job_scheduler.sv
// tb/tb_crack_job_scheduler.sv - self-checking bench for crack_job_scheduler
module tb_crack_job_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main N=4 DUT
  logic        m_start, m_abort;
  logic [31:0] m_pwd, m_eng_pwd, m_cyc;
  logic [3:0]  m_eng_rst, m_found, m_done;
  logic [23:0] m_from, m_to;
  logic        m_busy, m_jd, m_jf;
  logic [1:0]  m_je;

  crack_job_scheduler #(.NUM_ENGINES(4)) u_m (
    .clk(clk), .rst(rst), .i_start(m_start), .i_abort(m_abort), .i_target_pwd(m_pwd),
    .o_eng_rst(m_eng_rst), .o_eng_pwd(m_eng_pwd), .o_eng_from(m_from), .o_eng_to(m_to),
    .i_eng_found(m_found), .i_eng_done(m_done), .o_busy(m_busy), .o_job_done(m_jd),
    .o_job_found(m_jf), .o_job_engine(m_je), .o_job_cycles(m_cyc));

  // Secondary DUTs for slicing corners, sharing start
  logic        s_start;
  logic        s_abort = 1'b0;
  logic [31:0] s_pwd = 32'h30303030;

  logic [4:0]   r5, f5, d5;    logic [29:0]  fr5, to5;   logic [2:0] je5;
  logic [7:0]   r8, f8, d8;    logic [47:0]  fr8, to8;   logic [2:0] je8;
  logic [35:0]  r36, f36, d36; logic [215:0] fr36, to36; logic [5:0] je36;
  logic [9:0]   r10, f10, d10; logic [59:0]  fr10, to10; logic [3:0] je10;
  logic [31:0]  p5, p8, p36, p10, c5, c8, c36, c10;
  logic         b5, b8, b36, b10, jd5, jd8, jd36, jd10, jf5, jf8, jf36, jf10;

  crack_job_scheduler #(.NUM_ENGINES(5)) u_n5 (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort), .i_target_pwd(s_pwd),
    .o_eng_rst(r5), .o_eng_pwd(p5), .o_eng_from(fr5), .o_eng_to(to5),
    .i_eng_found(f5), .i_eng_done(d5), .o_busy(b5), .o_job_done(jd5),
    .o_job_found(jf5), .o_job_engine(je5), .o_job_cycles(c5));
  crack_job_scheduler #(.NUM_ENGINES(8)) u_n8 (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort), .i_target_pwd(s_pwd),
    .o_eng_rst(r8), .o_eng_pwd(p8), .o_eng_from(fr8), .o_eng_to(to8),
    .i_eng_found(f8), .i_eng_done(d8), .o_busy(b8), .o_job_done(jd8),
    .o_job_found(jf8), .o_job_engine(je8), .o_job_cycles(c8));
  crack_job_scheduler #(.NUM_ENGINES(36)) u_n36 (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort), .i_target_pwd(s_pwd),
    .o_eng_rst(r36), .o_eng_pwd(p36), .o_eng_from(fr36), .o_eng_to(to36),
    .i_eng_found(f36), .i_eng_done(d36), .o_busy(b36), .o_job_done(jd36),
    .o_job_found(jf36), .o_job_engine(je36), .o_job_cycles(c36));
  crack_job_scheduler #(.NUM_ENGINES(10)) u_n10 (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort), .i_target_pwd(s_pwd),
    .o_eng_rst(r10), .o_eng_pwd(p10), .o_eng_from(fr10), .o_eng_to(to10),
    .i_eng_found(f10), .i_eng_done(d10), .o_busy(b10), .o_job_done(jd10),
    .o_job_found(jf10), .o_job_engine(je10), .o_job_cycles(c10));

  // {from,to} of engine i in the DUT with n engines
  function automatic logic [11:0] get_slice(input int n, input int i);
    case (n)
      4:       return {m_from[i*6 +: 6], m_to[i*6 +: 6]};
      5:       return {fr5[i*6 +: 6], to5[i*6 +: 6]};
      8:       return {fr8[i*6 +: 6], to8[i*6 +: 6]};
      36:      return {fr36[i*6 +: 6], to36[i*6 +: 6]};
      default: return {fr10[i*6 +: 6], to10[i*6 +: 6]};
    endcase
  endfunction

  typedef struct {
    int n;
    int idx;
    int from;
    int to;
  } slice_vec_t;

  // One job on the main DUT. Outcome expected from the rules: abort -> miss,
  // otherwise lowest hit index, otherwise (all done) miss; cycles = RUN cycles.
  task automatic run_job(input int k, input logic [3:0] f, input logic [3:0] d,
                         input logic [31:0] pwd, input bit hold, input bit ab,
                         input bit sr, input string tag);
    bit ef;
    int ee;
    ef = 1'b0;
    ee = 0;
    if (!ab) for (int i = 3; i >= 0; i--) if (f[i]) begin ef = 1'b1; ee = i; end
    m_pwd = pwd; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    chk({tag, "_busy_load"}, m_busy, 1);
    chk({tag, "_rst_load"}, m_eng_rst, 4'hF);
    m_found = 4'($urandom); m_done = 4'($urandom);
    tick();
    chk({tag, "_rst_settle"}, m_eng_rst, 4'h0);
    m_found = 4'($urandom); m_done = 4'($urandom);
    tick();
    m_found = 4'h0; m_done = 4'h0;
    if (hold) begin m_start = 1'b1; m_pwd = ~pwd; end
    for (int c = 1; c < k; c++) tick();
    chk({tag, "_no_early_done"}, m_jd, 0);
    m_start = 1'b0;
    if (ab) m_abort = 1'b1;
    else begin m_found = f; m_done = d; end
    tick();
    m_abort = 1'b0;
    chk({tag, "_job_done"}, m_jd, 1);
    chk({tag, "_job_found"}, m_jf, ef);
    if (ef) chk({tag, "_job_engine"}, m_je, ee);
    if (!ab) chk({tag, "_job_cycles"}, m_cyc, k);
    chk({tag, "_rst_report"}, m_eng_rst, 4'hF);
    chk({tag, "_pwd_report"}, m_eng_pwd, pwd);
    m_found = 4'h0; m_done = 4'h0;
    if (sr) m_start = 1'b1;
    tick();
    m_start = 1'b0;
    chk({tag, "_single_pulse"}, m_jd, 0);
    chk({tag, "_idle_busy"}, m_busy, 0);
    // Bounded recovery if the DUT is stuck busy
    for (int c = 0; c < 50 && m_busy; c++) begin m_abort = 1'b1; tick(); end
    m_abort = 1'b0;
  endtask

  slice_vec_t tbl[13];

  initial begin
    tbl[0]  = '{4, 0, 0, 8};    tbl[1]  = '{4, 1, 9, 17};
    tbl[2]  = '{4, 2, 18, 26};  tbl[3]  = '{4, 3, 27, 35};
    tbl[4]  = '{5, 4, 32, 35};  tbl[5]  = '{5, 3, 24, 31};
    tbl[6]  = '{8, 7, 35, 35};  tbl[7]  = '{8, 6, 30, 34};
    tbl[8]  = '{36, 0, 0, 0};   tbl[9]  = '{36, 17, 17, 17};
    tbl[10] = '{36, 35, 35, 35}; tbl[11] = '{10, 8, 32, 35};
    tbl[12] = '{10, 9, 0, 0};

    rst = 1'b1;
    m_start = 1'b0; m_abort = 1'b0; m_pwd = '0; m_found = '0; m_done = '0;
    s_start = 1'b0;
    f5 = '0; d5 = '0; f8 = '0; d8 = '0; f36 = '0; d36 = '0; f10 = '0; d10 = '0;
    #2;
    chk("reset_eng_rst", m_eng_rst, 4'hF);
    chk("reset_busy", m_busy, 0);
    chk("reset_job_done", m_jd, 0);
    chk("reset_job_found", m_jf, 0);
    chk("reset_job_engine", m_je, 0);
    chk("reset_cycles", m_cyc, 0);
    chk("reset_pwd", m_eng_pwd, 0);
    chk("reset_from", {40'd0, m_from}, 64'd0);
    chk("reset_to", {40'd0, m_to}, 64'd0);
    tick();
    rst = 1'b0;

    // Hit on engine 0 after 50 RUN cycles, target "0a00"
    run_job(50, 4'b0001, 4'b0000, 32'h30613030, 0, 0, 0, "t1");
    // All done, none found
    run_job(7, 4'b0000, 4'b1111, 32'h31313131, 0, 0, 0, "t2");
    // Engines 3,1 hit while 0,2 done: lowest hit wins
    run_job(12, 4'b1010, 4'b0101, 32'h7a7a7a7a, 0, 0, 0, "t3");
    // Abort 10 cycles into RUN; start in REPORT ignored
    run_job(10, 4'b0000, 4'b0000, 32'h61626364, 0, 1, 1, "t6");
    // Start held during RUN has no effect
    run_job(20, 4'b0100, 4'b0000, 32'h39383736, 1, 0, 0, "t7");

    // Slicing corners on the secondary DUTs
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int t = 0; t < 13; t++)
      chk($sformatf("slice_n%0d_e%0d", tbl[t].n, tbl[t].idx),
          get_slice(tbl[t].n, tbl[t].idx), {6'(tbl[t].from), 6'(tbl[t].to)});
    tick();
    chk("n10_rst_settle", r10, 10'h200);
    chk("n36_rst_settle", r36, 36'h0);
    d5 = '1; d8 = '1; d36 = '1; d10 = 10'h1FF;
    tick();
    chk("n10_run_no_done", jd10, 0);
    tick();
    chk("n10_done_miss", {jd10, jf10}, 2'b10);
    chk("n10_cycles", c10, 1);
    chk("n36_done", jd36, 1);
    d5 = '0; d8 = '0; d36 = '0; d10 = '0;
    tick();

    // Randomized jobs vs. rule-based model
    for (int t = 0; t < 24; t++) begin
      logic [3:0] f, d;
      f = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = (f == 4'h0) ? 4'hF : 4'($urandom);
      run_job(int'($urandom_range(1, 40)), f, d, $urandom, 0, 0, 0, $sformatf("rnd%0d", t));
    end

    // Async reset mid-RUN
    m_pwd = 32'h31323334; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", m_busy, 0);
    chk("rstmid_eng_rst", m_eng_rst, 4'hF);
    chk("rstmid_cycles", m_cyc, 0);
    chk("rstmid_pwd", m_eng_pwd, 0);
    chk("rstmid_job_done", m_jd, 0);
    #1 rst = 1'b0;
    tick();
    chk("rstmid_no_done", m_jd, 0);
    chk("rstmid_idle", m_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
